// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts two WIDTH-bit operands, adds them LSB first
// one bit per clock through two half adders and a carry flop, then presents the result.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Half adder packed as {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [1:0]        h1_s;
    logic [1:0]        h2_s;
    logic              bit_carry_s;

    // State and datapath registers; the result registers are separate from the
    // shift register so the reported sum holds steady until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= CNT_ZERO;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic and one bit of serial addition per RUN cycle.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        h1_s        = half_add(a_q[0], b_q[0]);
        h2_s        = half_add(h1_s[0], carry_q);
        bit_carry_s = h1_s[1] | h2_s[1];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d   = {h2_s[0], res_q[WIDTH-1:1]};
                carry_d = bit_carry_s;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {h2_s[0], res_q[WIDTH-1:1]};
                    cout_d  = bit_carry_s;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, hand-written corner
// sequences and a random run, all scored against a queue of expected sums.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp;
        int               stall;
    } vec_t;

    int             errors;
    int             checks;
    int             busy_cnt;
    logic [WIDTH:0] exp_q[$];
    vec_t           vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Commit the current inputs for one clock: record handshakes in the
    // scoreboard, then advance to the next falling edge.
    task automatic cycle();
        logic [WIDTH:0] e;
        if (busy) busy_cnt++;
        if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %0h, required no result", {out_cout, out_sum});
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", 32'({out_cout, out_sum}), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH:0] exp, input int stall, input bit rand_rdy);
        int n;
        busy_cnt = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin cycle(); n++; end
        check("accept_timeout", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            out_ready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b0;
            cycle();
            n++;
        end
        check("latency", 32'(n), 32'(WIDTH));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_result", 32'({out_cout, out_sum}), 32'(exp));
            cycle();
        end
        check("result", 32'({out_cout, out_sum}), 32'(exp));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        check("back_idle", 32'({in_ready, out_valid, busy}), 32'b100);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               n;
        bit               seen;

        errors = 0;
        checks = 0;
        busy_cnt = 0;
        vecs[0] = '{8'h05, 8'h03, 9'h008, 0};
        vecs[1] = '{8'hFF, 8'h01, 9'h100, 0};
        vecs[2] = '{8'h05, 8'h03, 9'h008, 5};
        vecs[3] = '{8'h00, 8'h00, 9'h000, 1};
        vecs[4] = '{8'hFF, 8'hFF, 9'h1FE, 2};
        vecs[5] = '{8'h80, 8'h80, 9'h100, 0};
        vecs[6] = '{8'h7F, 8'h01, 9'h080, 3};
        vecs[7] = '{8'hAA, 8'h55, 9'h0FF, 0};
        vecs[8] = '{8'h5A, 8'hA7, 9'h101, 1};
        vecs[9] = '{8'h12, 8'h34, 9'h046, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        check("reset_result", 32'({out_cout, out_sum}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, 1'b0);

        // Reset three cycles into a run: everything clears and no result appears.
        in_a = 8'hAA;
        in_b = 8'h55;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        check("async_reset_result", 32'({out_cout, out_sum}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            if (out_valid) seen = 1'b1;
            cycle();
        end
        check("no_result_after_reset", 32'(seen), 32'd0);
        out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        in_a = 8'h80;
        in_b = 8'h80;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_a = 8'h7F;
        in_b = 8'h01;
        n = 0;
        while (!out_valid && n < 100) begin cycle(); n++; end
        check("b2b_latency", 32'(n), 32'(WIDTH));
        check("b2b_done_in_ready", 32'(in_ready), 32'd0);
        check("b2b_first", 32'({out_cout, out_sum}), 32'h100);
        cycle();
        check("b2b_idle", 32'({in_ready, out_valid, busy}), 32'b100);
        check("b2b_one_accept", 32'(exp_q.size()), 32'd0);
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin cycle(); n++; end
        check("b2b_second", 32'({out_cout, out_sum}), 32'h080);
        cycle();
        out_ready = 1'b0;

        for (int k = 0; k < 1000; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            do_op(ra, rb, {1'b0, ra} + {1'b0, rb}, int'($urandom_range(3, 0)), 1'b1);
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
